// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl
// ----------------------------------------------------------------------------
// Hazard and sequencing controller for a classic 5-stage in-order pipeline.
// It detects load-use hazards and taken branches, and it runs a small FSM
// with four states: FILL (post-reset warm-up), RUN, DRAIN (bubbles before a
// halt) and HALTED. The control outputs are a Mealy function of the
// registered state and the current ID/EX fields, so they take effect in the
// same cycle as the inputs. Two saturating performance counters record the
// stalls and flushes the block issues.
//
// Parameters
//   FILL_CYCLES  : rising edges spent in FILL after reset (at least 1 is used)
//   DRAIN_CYCLES : rising edges spent in DRAIN before HALTED (at least 1 is used)
//   CNT_W        : width of each performance counter
//
// Ports
//   clk, rst_n         : clock and asynchronous active-low reset
//   id_rs1, id_rs2     : source register fields of the IF/ID register
//   id_uses_rs2        : the ID instruction really reads rs2
//   ex_rd              : destination register of the ID/EX instruction
//   ex_mem_read        : the ID/EX instruction is a load
//   ex_branch, ex_zero : branch in EX, and the ALU zero flag (branch taken)
//   halt_req           : level request to stop fetching
//   pc_write           : PC load enable
//   if_id_write        : IF/ID load enable
//   if_id_flush        : replace IF/ID with a NOP
//   id_ex_flush        : clear the ID/EX control bits (insert a bubble)
//   pipe_valid         : pipeline holds valid instructions (not in FILL)
//   halted             : FSM is in HALTED
//   state              : FILL=0, RUN=1, DRAIN=2, HALTED=3
//   stall_cnt          : load-use stalls issued (saturating)
//   flush_cnt          : taken-branch flushes issued (saturating)
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int FILL_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_valid,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // The phase counters count 0 .. N-1; the last value marks the final edge.
    localparam int FILL_W  = (FILL_CYCLES  > 1) ? $clog2(FILL_CYCLES)  : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [FILL_W-1:0]  FILL_LAST  =
        FILL_W'((FILL_CYCLES > 1) ? FILL_CYCLES - 1 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    state_t               cur_state;
    state_t               nxt_state;
    logic [FILL_W-1:0]    fill_cnt;
    logic [FILL_W-1:0]    fill_nxt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_W-1:0]   drain_nxt;
    logic                 lu;
    logic                 tk;
    logic                 stall_inc;
    logic                 flush_inc;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    assign tk = ex_branch && ex_zero;

    assign state      = cur_state;
    assign pipe_valid = (cur_state != S_FILL);
    assign halted     = (cur_state == S_HALTED);

    // ------------------------------------------------------------------------
    // Next state and Mealy outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        nxt_state   = cur_state;
        fill_nxt    = fill_cnt;
        drain_nxt   = drain_cnt;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        unique case (cur_state)
            S_FILL: begin
                // Fetch runs freely, but nothing reaches EX until warm-up ends.
                id_ex_flush = 1'b1;
                if (fill_cnt == FILL_LAST) begin
                    nxt_state = S_RUN;
                    fill_nxt  = '0;
                end else begin
                    fill_nxt  = fill_cnt + FILL_W'(1);
                end
            end

            S_RUN: begin
                // A taken branch squashes the younger instructions anyway, so
                // it wins over a load-use stall seen in the same cycle.
                if (tk) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (lu) begin
                    // The bubble clears ex_mem_read, so this lasts one cycle.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end
                if (halt_req) begin
                    nxt_state = S_DRAIN;
                    drain_nxt = '0;
                end
            end

            S_DRAIN: begin
                // Freeze fetch and feed bubbles; IF/ID keeps the instruction
                // to resume with. A branch already in EX must still redirect.
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (tk) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    flush_inc   = 1'b1;
                end
                if (!halt_req) begin
                    nxt_state = S_RUN;
                    drain_nxt = '0;
                end else if (drain_cnt == DRAIN_LAST) begin
                    nxt_state = S_HALTED;
                    drain_nxt = '0;
                end else begin
                    drain_nxt = drain_cnt + DRAIN_W'(1);
                end
            end

            S_HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (!halt_req) begin
                    nxt_state = S_RUN;
                end
            end

            default: begin
                nxt_state = S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, phase counters and saturating performance counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FILL;
            fill_cnt  <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register here sample
            // the pre-edge values, independent of statement order.
            cur_state <= nxt_state;
            fill_cnt  <= fill_nxt;
            drain_cnt <= drain_nxt;
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for pipeline_hazard_ctrl. Two instances share their
// inputs: one with default parameters and one with CNT_W=4, which makes the
// counter saturation easy to reach. A behavioural reference model tracks the
// phase as a plain integer and counts warm-up and drain cycles in integers.
// Inputs change 1 ns after a rising edge; outputs are compared on the
// falling edge, and then the model is advanced for the coming rising edge.
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int FILL_N  = 2;
    localparam int DRAIN_N = 3;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch;
    logic        ex_zero;
    logic        halt_req;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic        pipe_valid, halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_flush4;
    logic        pipe_valid4, halted4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    pipeline_hazard_ctrl #(.FILL_CYCLES(FILL_N), .DRAIN_CYCLES(DRAIN_N), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .halt_req(halt_req),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pipe_valid(pipe_valid), .halted(halted), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.FILL_CYCLES(FILL_N), .DRAIN_CYCLES(DRAIN_N), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .halt_req(halt_req),
        .pc_write(pc_write4), .if_id_write(if_id_write4),
        .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .pipe_valid(pipe_valid4), .halted(halted4), .state(state4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Scoreboard counts
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: phase 0=FILL 1=RUN 2=DRAIN 3=HALTED, integer counters
    // ------------------------------------------------------------------------
    int m_phase, m_fill_seen, m_drain_seen;
    int m_stalls, m_flushes, m_stalls4, m_flushes4;

    task automatic model_reset();
        m_phase = 0; m_fill_seen = 0; m_drain_seen = 0;
        m_stalls = 0; m_flushes = 0; m_stalls4 = 0; m_flushes4 = 0;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    // Compare every output with the model's view of the current cycle, then
    // move the model across the next rising edge.
    task automatic check_and_advance();
        bit hz, br;
        bit e_pc, e_ifw, e_iff, e_idf;
        hz = ex_mem_read && ex_rd != 0 &&
             (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
        br = ex_branch && ex_zero;

        // Default RUN behaviour, then overrides per phase.
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0;
        if (m_phase == 0) e_idf = 1;
        if (m_phase == 1 && br) begin e_iff = 1; e_idf = 1; end
        if (m_phase == 1 && !br && hz) begin e_pc = 0; e_ifw = 0; e_idf = 1; end
        if (m_phase >= 2) begin e_pc = 0; e_ifw = 0; e_idf = 1; end
        if (m_phase == 2 && br) begin e_pc = 1; e_ifw = 1; e_iff = 1; end

        check("state",       32'(state),       32'(m_phase));
        check("state_w4",    32'(state4),      32'(m_phase));
        check("pc_write",    32'(pc_write),    32'(e_pc));
        check("if_id_write", 32'(if_id_write), 32'(e_ifw));
        check("if_id_flush", 32'(if_id_flush), 32'(e_iff));
        check("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
        check("pipe_valid",  32'(pipe_valid),  32'(m_phase != 0));
        check("halted",      32'(halted),      32'(m_phase == 3));
        check("stall_cnt",   32'(stall_cnt),   32'(m_stalls));
        check("flush_cnt",   32'(flush_cnt),   32'(m_flushes));
        check("stall_cnt4",  32'(stall_cnt4),  32'(m_stalls4));
        check("flush_cnt4",  32'(flush_cnt4),  32'(m_flushes4));

        case (m_phase)
            0: begin
                m_fill_seen++;
                if (m_fill_seen >= FILL_N) begin m_phase = 1; m_fill_seen = 0; end
            end
            1: begin
                if (br) begin
                    m_flushes = sat(m_flushes, 65535); m_flushes4 = sat(m_flushes4, 15);
                end else if (hz) begin
                    m_stalls = sat(m_stalls, 65535); m_stalls4 = sat(m_stalls4, 15);
                end
                if (halt_req) begin m_phase = 2; m_drain_seen = 0; end
            end
            2: begin
                if (br) begin
                    m_flushes = sat(m_flushes, 65535); m_flushes4 = sat(m_flushes4, 15);
                end
                if (!halt_req) begin
                    m_phase = 1; m_drain_seen = 0;
                end else begin
                    m_drain_seen++;
                    if (m_drain_seen >= DRAIN_N) begin m_phase = 3; m_drain_seen = 0; end
                end
            end
            default: begin
                if (!halt_req) m_phase = 1;
            end
        endcase
    endtask

    // One clock cycle: drive, check on the falling edge, land 1 ns past the rise.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic b,
                        input logic z, input logic hr);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch = b; ex_zero = z; halt_req = hr;
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic hr);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hr);
    endtask

    // Assert reset between edges; FILL values and cleared counters must show
    // up without any clock edge. Release 1 ns after the next rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_state",       32'(state),       32'd0);
        check("rst_pc_write",    32'(pc_write),    32'd1);
        check("rst_if_id_write", 32'(if_id_write), 32'd1);
        check("rst_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check("rst_if_id_flush", 32'(if_id_flush), 32'd0);
        check("rst_pipe_valid",  32'(pipe_valid),  32'd0);
        check("rst_halted",      32'(halted),      32'd0);
        check("rst_stall_cnt",   32'(stall_cnt),   32'd0);
        check("rst_flush_cnt",   32'(flush_cnt),   32'd0);
        check("rst_flush_cnt4",  32'(flush_cnt4),  32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic hr_level;
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0; halt_req = 1'b0;
        model_reset();

        // Reset release: two FILL edges, then RUN with a valid pipeline.
        do_reset();
        idle(1'b0);
        idle(1'b0);
        check("fill_done_state", 32'(state),      32'd1);
        check("fill_done_valid", 32'(pipe_valid), 32'd1);

        // Load-use through rs2, then the same load with rs2 unused: no stall.
        step(5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_rs2_stall_cnt", 32'(stall_cnt), 32'd1);
        step(5'd7, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_no_rs2_stall_cnt", 32'(stall_cnt), 32'd1);

        // Hazard and taken branch together: flush wins, no stall counted.
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        check("lu_tk_flush_cnt", 32'(flush_cnt), 32'd1);
        check("lu_tk_stall_cnt", 32'(stall_cnt), 32'd1);
        // Load into x0 never stalls.
        step(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("x0_stall_cnt", 32'(stall_cnt), 32'd1);

        // Halt held: one RUN cycle, three DRAIN cycles, then HALTED.
        idle(1'b1);
        check("drain_entry", 32'(state), 32'd2);
        idle(1'b1);
        idle(1'b1);
        check("drain_third", 32'(state), 32'd2);
        idle(1'b1);
        check("halt_state",  32'(state),    32'd3);
        check("halt_flag",   32'(halted),   32'd1);
        check("halt_pc",     32'(pc_write), 32'd0);
        idle(1'b1);
        idle(1'b0);
        check("resume_state", 32'(state), 32'd1);

        // Halt dropped on DRAIN cycle 2 returns to RUN on that edge.
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        check("drain_abort_state", 32'(state), 32'd1);

        // Async reset in the middle of DRAIN, with non-zero counters.
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("pre_rst_drain", 32'(state), 32'd2);
        do_reset();

        // 20 taken branches: 4-bit counter sticks at 15, 16-bit reads 20.
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 20; i++) begin
            step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("sat_flush_cnt4", 32'(flush_cnt4), 32'd15);
        check("sat_flush_cnt",  32'(flush_cnt),  32'd20);

        // Randomized traffic with a sticky halt level and rare resets.
        hr_level = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] rs1, rs2, rd;
            if ($urandom_range(0, 5) == 0) hr_level = ~hr_level;
            if ($urandom_range(0, 3) == 0) begin
                rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            end else begin
                rs1 = 5'($urandom_range(0, 3));
                rs2 = 5'($urandom_range(0, 3));
                rd  = 5'($urandom_range(0, 3));
            end
            step(rs1, rs2, 1'($urandom), rd, 1'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom), hr_level);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
